// File: rtl/iq_frame_buf.sv
// IQ frame buffer: boxcar decimator feeding ping-pong frame storage, with a
// ready/valid streaming reader toward the FFT and frame-drop accounting.
module iq_frame_buf #(
  parameter int DECIM      = 8,
  parameter int FRAME_LOG2 = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [15:0] insin,
  input  logic signed [15:0] incos,
  input  logic               in_valid,
  output logic signed [15:0] out_sin,
  output logic signed [15:0] out_cos,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_eop,
  output logic               overflow,
  output logic [7:0]         drop_cnt
);

  localparam int L     = $clog2(DECIM);
  localparam int AW    = 16 + L;
  localparam int FRAME = 1 << FRAME_LOG2;
  localparam logic [L-1:0]          DCNT_LAST = L'(DECIM - 1);
  localparam logic [FRAME_LOG2-1:0] IDX_LAST  = FRAME_LOG2'(FRAME - 1);

  typedef enum logic {W_FILL, W_DROP} wstate_t;
  typedef enum logic {R_IDLE, R_SEND} rstate_t;

  // Floor of the group mean: arithmetic shift of the full-width sum.
  function automatic logic signed [15:0] floor_mean(input logic signed [AW-1:0] s);
    return 16'(s >>> L);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic signed [AW-1:0]    acc_sin_p0, acc_cos_p0;
  logic [L-1:0]            dcnt_p0;
  logic signed [AW-1:0]    sum_sin, sum_cos;
  logic                    dec_vld;
  logic signed [15:0]      dec_sin, dec_cos;

  wstate_t                 w_state;
  logic [FRAME_LOG2-1:0]   wr_idx;
  logic                    wr_bank;
  logic                    drop_first;
  logic                    wrap, recheck, wr_en, wr_sel, set_full;

  rstate_t                 r_state;
  logic [FRAME_LOG2-1:0]   rd_idx;
  logic                    rd_bank;
  logic                    fetched;
  logic                    accept, frame_done, load;
  logic [31:0]             rd_word;

  logic [1:0]              full, set_vec, clr_vec;
  logic [31:0]             mem [2*FRAME];

  // Decimator datapath and writer/reader handshake terms.
  always_comb begin
    sum_sin    = acc_sin_p0 + $signed({{L{insin[15]}}, insin});
    sum_cos    = acc_cos_p0 + $signed({{L{incos[15]}}, incos});
    dec_vld    = in_valid && (dcnt_p0 == DCNT_LAST);
    dec_sin    = floor_mean(sum_sin);
    dec_cos    = floor_mean(sum_cos);
    wrap       = (wr_idx == IDX_LAST);
    recheck    = (w_state == W_DROP) && (wr_idx == '0) && !drop_first;
    wr_en      = dec_vld && ((w_state == W_FILL) || (recheck && !full[~wr_bank]));
    wr_sel     = (w_state == W_FILL) ? wr_bank : ~wr_bank;
    set_full   = dec_vld && (w_state == W_FILL) && wrap;
    set_vec    = set_full ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    accept     = out_valid && out_ready;
    frame_done = accept && out_eop;
    clr_vec    = frame_done ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    load       = (r_state == R_SEND) && !fetched && (!out_valid || out_ready);
    rd_word    = mem[{rd_bank, rd_idx}];
  end

  // Stage p0: accumulate DECIM valid samples per channel, restart after each group.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_sin_p0 <= '0;
      acc_cos_p0 <= '0;
      dcnt_p0    <= '0;
    end else if (in_valid) begin
      dcnt_p0 <= dcnt_p0 + L'(1);
      if (dec_vld) begin
        acc_sin_p0 <= '0;
        acc_cos_p0 <= '0;
      end else begin
        acc_sin_p0 <= sum_sin;
        acc_cos_p0 <= sum_cos;
      end
    end
  end

  // Frame storage write port (contents are not cleared by reset).
  always_ff @(posedge clock) begin
    if (wr_en) mem[{wr_sel, wr_idx}] <= {dec_sin, dec_cos};
  end

  // Bank-full flags: writer sets and reader clears act on different banks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) full <= 2'b00;
    else       full <= (full | set_vec) & ~clr_vec;
  end

  // Writer FSM: fill banks alternately, drop whole frames when both are full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state    <= W_FILL;
      wr_idx     <= '0;
      wr_bank    <= 1'b0;
      drop_first <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= 8'd0;
    end else if (dec_vld) begin
      wr_idx <= wr_idx + FRAME_LOG2'(1);
      case (w_state)
        W_FILL: begin
          if (wrap) begin
            if (!full[~wr_bank]) begin
              wr_bank <= ~wr_bank;
            end else begin
              w_state    <= W_DROP;
              drop_first <= 1'b1;
              overflow   <= 1'b1;
              drop_cnt   <= sat_inc(drop_cnt);
            end
          end
        end
        W_DROP: begin
          drop_first <= 1'b0;
          // The decision for the next frame is taken on its first sample, so
          // a reader that frees a bank meanwhile lets that frame through.
          if (recheck) begin
            if (!full[~wr_bank]) begin
              wr_bank <= ~wr_bank;
              w_state <= W_FILL;
            end else begin
              overflow <= 1'b1;
              drop_cnt <= sat_inc(drop_cnt);
            end
          end
        end
        default: w_state <= W_FILL;
      endcase
    end
  end

  // Reader FSM with output register: loads a sample whenever the slot is free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= R_IDLE;
      rd_idx    <= '0;
      rd_bank   <= 1'b0;
      fetched   <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_sin   <= '0;
      out_cos   <= '0;
    end else begin
      if (load) begin
        out_sin   <= rd_word[31:16];
        out_cos   <= rd_word[15:0];
        out_valid <= 1'b1;
        out_sop   <= (rd_idx == '0);
        out_eop   <= (rd_idx == IDX_LAST);
        rd_idx    <= rd_idx + FRAME_LOG2'(1);
        fetched   <= (rd_idx == IDX_LAST);
      end else if (accept) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
      case (r_state)
        R_IDLE: begin
          if (full[rd_bank]) begin
            r_state <= R_SEND;
            rd_idx  <= '0;
            fetched <= 1'b0;
          end
        end
        R_SEND: begin
          if (frame_done) begin
            rd_bank <= ~rd_bank;
            fetched <= 1'b0;
            if (!full[~rd_bank]) r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iq_frame_buf.sv
// Bench for iq_frame_buf (DECIM=8, 8-sample frames): scoreboard of expected
// decimated samples, checked as the FFT side accepts them.
module tb_iq_frame_buf;

  localparam int DECIM = 8;
  localparam int FL    = 3;
  localparam int FRAME = 1 << FL;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [15:0] insin, incos, out_sin, out_cos;
  logic               in_valid, out_valid, out_ready, out_sop, out_eop, overflow;
  logic [7:0]         drop_cnt;

  iq_frame_buf #(.DECIM(DECIM), .FRAME_LOG2(FL)) dut (
    .clock(clock), .reset(reset), .insin(insin), .incos(incos),
    .in_valid(in_valid), .out_sin(out_sin), .out_cos(out_cos),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic signed [15:0] s;
    logic signed [15:0] c;
    logic               sop;
    logic               eop;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_checks = 0, n_pass = 0;
  int         cyc = 0, n_acc = 0;
  int         last_eop_cyc = -100, last_sop_cyc = 0, last_gap = 0, frame_span = 0;
  int         m_cnt = 0, m_sum_s = 0, m_sum_c = 0, m_pos = 0;
  bit         rand_ready = 0;
  bit         prev_hold = 0;
  logic [34:0] prev_out;

  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor: hold stability while stalled, scoreboard on acceptance.
  always @(negedge clock) begin
    if (reset) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        n_checks++;
        if ({out_valid, out_sop, out_eop, out_sin, out_cos} !== prev_out)
          $display("FAIL hold_stable: got %h required %h",
                   {out_valid, out_sop, out_eop, out_sin, out_cos}, prev_out);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_acc++;
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_output: got sin=%0d cos=%0d sop=%b eop=%b required nothing",
                   out_sin, out_cos, out_sop, out_eop);
        end else begin
          mon_e = q.pop_front();
          if ({out_sin, out_cos, out_sop, out_eop} !== {mon_e.s, mon_e.c, mon_e.sop, mon_e.eop})
            $display("FAIL sample: got sin=%0d cos=%0d sop=%b eop=%b required sin=%0d cos=%0d sop=%b eop=%b",
                     out_sin, out_cos, out_sop, out_eop, mon_e.s, mon_e.c, mon_e.sop, mon_e.eop);
          else n_pass++;
        end
        if (out_sop) begin
          last_gap     = cyc - last_eop_cyc;
          last_sop_cyc = cyc;
        end
        if (out_eop) begin
          last_eop_cyc = cyc;
          frame_span   = cyc - last_sop_cyc;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_valid, out_sop, out_eop, out_sin, out_cos};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish required finish before 400000 ns");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    q.delete();
    m_cnt = 0; m_sum_s = 0; m_sum_c = 0; m_pos = 0;
  endtask

  // One input sample; the model pushes the group mean on every DECIM-th sample.
  task automatic drive_sample(input int s, input int c, input bit keep, input bit gap);
    exp_t e;
    insin = 16'(s); incos = 16'(c); in_valid = 1'b1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    m_sum_s += s; m_sum_c += c; m_cnt++;
    if (m_cnt == DECIM) begin
      if (keep) begin
        e.s = 16'(m_sum_s >>> $clog2(DECIM));
        e.c = 16'(m_sum_c >>> $clog2(DECIM));
        e.sop = (m_pos == 0);
        e.eop = (m_pos == FRAME - 1);
        q.push_back(e);
      end
      m_pos = (m_pos + 1) % FRAME;
      m_cnt = 0; m_sum_s = 0; m_sum_c = 0;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    if (gap) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
  endtask

  // kind 0: constant 100/-1, 1: ramp sin=i cos=-1-i, else random.
  task automatic drive_frame(input int kind, input bit keep, input bit gap);
    logic signed [15:0] rs, rc;
    for (int i = 0; i < FRAME * DECIM; i++) begin
      rs = 16'($urandom); rc = 16'($urandom);
      case (kind)
        0:       drive_sample(100, -1, keep, gap);
        1:       drive_sample(i, -1 - i, keep, gap);
        default: drive_sample(int'(rs), int'(rc), keep, gap);
      endcase
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 600 && q.size() != 0; k++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL %s_drain: got %0d samples pending required 0", name, q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; insin = '0; incos = '0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else n_pass++;
    n_checks++; if (out_sop !== 1'b0) $display("FAIL reset_out_sop: got %b required 0", out_sop); else n_pass++;
    n_checks++; if (out_eop !== 1'b0) $display("FAIL reset_out_eop: got %b required 0", out_eop); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", overflow); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt); else n_pass++;
    n_checks++; if (out_sin !== 16'sd0) $display("FAIL reset_out_sin: got %0d required 0", out_sin); else n_pass++;
    n_checks++; if (out_cos !== 16'sd0) $display("FAIL reset_out_cos: got %0d required 0", out_cos); else n_pass++;
    model_clear();
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_constant_latency();
    out_ready = 1'b1;
    drive_frame(0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL latency_edge0: got %b required 0", out_valid); else n_pass++;
    @(posedge clock); #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL latency_edge1: got %b required 0", out_valid); else n_pass++;
    @(posedge clock); #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL latency_edge2: got %b required 1", out_valid); else n_pass++;
    wait_drain("constant");
  endtask

  task automatic test_ramp();
    out_ready = 1'b1;
    drive_frame(1, 1'b1, 1'b0);
    wait_drain("ramp");
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    drive_frame(0, 1'b1, 1'b1);
    wait_drain("gaps");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_frame(2, 1'b1, 1'b0);
    drive_frame(2, 1'b1, 1'b0);
    wait_drain("back_to_back");
    n_checks++;
    if (frame_span !== FRAME - 1) $display("FAIL stream_span: got %0d cycles required %0d", frame_span, FRAME - 1);
    else n_pass++;
  endtask

  task automatic test_random_ready();
    int base;
    base = n_acc;
    rand_ready = 1;
    for (int f = 0; f < 4; f++) drive_frame(2, 1'b1, 1'b0);
    wait_drain("random_ready");
    rand_ready = 0; out_ready = 1'b1;
    n_checks++;
    if (n_acc - base !== 4 * FRAME) $display("FAIL accepted_count: got %0d required %0d", n_acc - base, 4 * FRAME);
    else n_pass++;
    n_checks++;
    if (drop_cnt !== 8'd0) $display("FAIL random_no_drop: got %0d required 0", drop_cnt);
    else n_pass++;
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    drive_frame(2, 1'b1, 1'b0);
    drive_frame(2, 1'b1, 1'b0);
    drive_frame(2, 1'b0, 1'b0);
    n_checks++; if (overflow !== 1'b1) $display("FAIL overflow_flag: got %b required 1", overflow); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd1) $display("FAIL drop_cnt_one: got %0d required 1", drop_cnt); else n_pass++;
    n_checks++; if ({out_valid, out_sop} !== 2'b11) $display("FAIL stalled_head: got valid/sop %b required 11", {out_valid, out_sop}); else n_pass++;
    out_ready = 1'b1;
    wait_drain("overflow_stored");
    n_checks++;
    if (last_gap > 2 || last_gap < 1) $display("FAIL frame_switch_gap: got %0d cycles required 1..2", last_gap);
    else n_pass++;
    drive_frame(2, 1'b1, 1'b0);
    wait_drain("overflow_after");
    n_checks++; if (drop_cnt !== 8'd1) $display("FAIL drop_cnt_after: got %0d required 1", drop_cnt); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %b required 1", overflow); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] rs;
    out_ready = 1'b0;
    drive_frame(2, 1'b1, 1'b0);
    for (int i = 0; i < FRAME * DECIM / 2; i++) begin
      rs = 16'($urandom);
      drive_sample(int'(rs), -int'(rs), 1'b1, 1'b0);
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b required 1", out_valid); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b required 0", out_valid); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL async_reset_drop_cnt: got %0d required 0", drop_cnt); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL async_reset_overflow: got %b required 0", overflow); else n_pass++;
    model_clear();
    @(posedge clock); #2;
    reset = 1'b0;
    @(posedge clock); #1;
    out_ready = 1'b1;
    drive_frame(1, 1'b1, 1'b0);
    wait_drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_constant_latency();
    test_ramp();
    test_gaps();
    test_back_to_back();
    test_random_ready();
    test_overflow();
    test_reset_mid();
    repeat (4) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
